ecc_secded_pipe: RTL

ECC_SECDED_PIPE -- requirements
Module: ecc_secded_pipe

---
 rtl/ecc_pkg.sv | 44 ++++
 rtl/ecc_secded_pipe_if.sv | 27 ++
 rtl/ecc_secded_dec.sv | 41 ++++
 rtl/ecc_secded_pipe.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared SECDED code helpers: column-code generation, width legality, encode and syndrome.
// Functions work on fixed maximum-width vectors; callers size-cast in and out.
package ecc_pkg;

  localparam int MAX_DW = 64;
  localparam int MAX_PW = 8;

  typedef logic [MAX_DW-1:0] wide_data_t;
  typedef logic [MAX_PW-1:0] wide_par_t;

  function automatic bit widths_legal(int dw, int pw);
    return (pw >= 3) && (pw <= MAX_PW) && (dw >= 1) && (dw <= MAX_DW) &&
           (((1 << (pw - 1)) - pw) >= dw);
  endfunction

  // j-th ascending pw-bit value with odd weight of at least 3
  function automatic wide_par_t col_code(int j, int pw);
    int        n;
    wide_par_t v;
    n = 0;
    for (int i = 0; i < (1 << pw); i++) begin
      v = wide_par_t'(i);
      if (($countones(v) % 2 == 1) && ($countones(v) >= 3)) begin
        if (n == j) return v;
        n++;
      end
    end
    return '0;
  endfunction

  function automatic wide_par_t encode(wide_data_t d, int dw, int pw);
    wide_par_t p;
    p = '0;
    for (int j = 0; j < dw; j++) begin
      if (d[j]) p = p ^ col_code(j, pw);
    end
    return p;
  endfunction

  function automatic wide_par_t calc_syndrome(wide_data_t d, wide_par_t par, int dw, int pw);
    return par ^ encode(d, dw, pw);
  endfunction

endpackage

// File: rtl/ecc_secded_pipe_if.sv
// Decode-side stream interface: stored-word input handshake and corrected-result output handshake.
interface ecc_secded_pipe_if #(
  parameter int DATA_WIDTH   = 11,
  parameter int PARITY_WIDTH = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [PARITY_WIDTH-1:0] in_parity;
  logic                    in_bypass;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_sbe;
  logic                    out_dbe;
  logic [PARITY_WIDTH-1:0] out_syndrome;

  modport master (
    output in_valid, in_data, in_parity, in_bypass, out_ready,
    input  in_ready, out_valid, out_data, out_sbe, out_dbe, out_syndrome
  );

  modport slave (
    input  in_valid, in_data, in_parity, in_bypass, out_ready,
    output in_ready, out_valid, out_data, out_sbe, out_dbe, out_syndrome
  );
endinterface

// File: rtl/ecc_secded_dec.sv
// Combinational syndrome classifier: corrects a single data-bit error, flags parity-bit
// errors as corrected and any other nonzero syndrome as uncorrectable.
module ecc_secded_dec
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH   = 11,
  parameter int PARITY_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [PARITY_WIDTH-1:0] syndrome_i,
  input  logic                    bypass_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    sbe_o,
  output logic                    dbe_o
);

  logic [DATA_WIDTH-1:0] hit;

  for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_col
    localparam logic [PARITY_WIDTH-1:0] CODE = PARITY_WIDTH'(col_code(j, PARITY_WIDTH));
    assign hit[j] = (syndrome_i == CODE);
  end

  always_comb begin
    data_o = data_i;
    sbe_o  = 1'b0;
    dbe_o  = 1'b0;
    if (!bypass_i && (syndrome_i != '0)) begin
      if (|hit) begin
        data_o = data_i ^ hit;
        sbe_o  = 1'b1;
      end else if ($onehot(syndrome_i)) begin
        // Lone check-bit flip: data already correct
        sbe_o = 1'b1;
      end else begin
        dbe_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ecc_secded_pipe.sv
// Two-stage SECDED decode pipeline with valid/ready flow control, saturating error
// counters and first-error log, plus a free-standing combinational encoder.
module ecc_secded_pipe
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH   = 11,
  parameter int PARITY_WIDTH = 5,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   enc_data,
  output logic [PARITY_WIDTH-1:0] enc_parity,
  ecc_secded_pipe_if.slave        bus,
  input  logic                    clr,
  output logic [CNT_WIDTH-1:0]    cnt_sbe,
  output logic [CNT_WIDTH-1:0]    cnt_dbe,
  output logic                    log_valid,
  output logic                    log_dbe,
  output logic [PARITY_WIDTH-1:0] log_syndrome
);

  if (!widths_legal(DATA_WIDTH, PARITY_WIDTH)) begin : g_bad_widths
    $error("ecc_secded_pipe: PARITY_WIDTH too small for DATA_WIDTH");
  end

  logic                    vld_p1_q, vld_p1_d, byp_p1_q, byp_p1_d;
  logic [DATA_WIDTH-1:0]   data_p1_q, data_p1_d;
  logic [PARITY_WIDTH-1:0] syn_p1_q, syn_p1_d;
  logic                    vld_p2_q, vld_p2_d, sbe_p2_q, sbe_p2_d, dbe_p2_q, dbe_p2_d;
  logic [DATA_WIDTH-1:0]   data_p2_q, data_p2_d;
  logic [PARITY_WIDTH-1:0] syn_p2_q, syn_p2_d;
  logic [CNT_WIDTH-1:0]    cnt_sbe_q, cnt_sbe_d, cnt_dbe_q, cnt_dbe_d;
  logic                    log_valid_q, log_valid_d, log_dbe_q, log_dbe_d;
  logic [PARITY_WIDTH-1:0] log_syn_q, log_syn_d;

  logic                    s1_adv, s2_adv, xfer;
  logic [PARITY_WIDTH-1:0] syn_in;
  logic [DATA_WIDTH-1:0]   dec_data;
  logic                    dec_sbe, dec_dbe;

  assign enc_parity = PARITY_WIDTH'(encode(wide_data_t'(enc_data), DATA_WIDTH, PARITY_WIDTH));
  assign syn_in     = PARITY_WIDTH'(calc_syndrome(wide_data_t'(bus.in_data),
                                                  wide_par_t'(bus.in_parity),
                                                  DATA_WIDTH, PARITY_WIDTH));

  ecc_secded_dec #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PARITY_WIDTH(PARITY_WIDTH)
  ) u_dec (
    .data_i    (data_p1_q),
    .syndrome_i(syn_p1_q),
    .bypass_i  (byp_p1_q),
    .data_o    (dec_data),
    .sbe_o     (dec_sbe),
    .dbe_o     (dec_dbe)
  );

  always_comb begin
    s2_adv      = !vld_p2_q || bus.out_ready;
    s1_adv      = !vld_p1_q || s2_adv;
    xfer        = vld_p2_q && bus.out_ready;
    vld_p1_d    = vld_p1_q;
    data_p1_d   = data_p1_q;
    syn_p1_d    = syn_p1_q;
    byp_p1_d    = byp_p1_q;
    vld_p2_d    = vld_p2_q;
    data_p2_d   = data_p2_q;
    sbe_p2_d    = sbe_p2_q;
    dbe_p2_d    = dbe_p2_q;
    syn_p2_d    = syn_p2_q;
    cnt_sbe_d   = cnt_sbe_q;
    cnt_dbe_d   = cnt_dbe_q;
    log_valid_d = log_valid_q;
    log_dbe_d   = log_dbe_q;
    log_syn_d   = log_syn_q;

    // S1: raw word, its syndrome and bypass
    if (s1_adv) begin
      vld_p1_d = bus.in_valid;
      if (bus.in_valid) begin
        data_p1_d = bus.in_data;
        syn_p1_d  = syn_in;
        byp_p1_d  = bus.in_bypass;
      end
    end

    // S2: corrected data and flags
    if (s2_adv) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        data_p2_d = dec_data;
        sbe_p2_d  = dec_sbe;
        dbe_p2_d  = dec_dbe;
        syn_p2_d  = syn_p1_q;
      end
    end

    // Bypass beats never carry flags, so flags alone qualify the count
    if (clr) begin
      cnt_sbe_d   = '0;
      cnt_dbe_d   = '0;
      log_valid_d = 1'b0;
      log_dbe_d   = 1'b0;
      log_syn_d   = '0;
    end else if (xfer && (sbe_p2_q || dbe_p2_q)) begin
      if (sbe_p2_q && (cnt_sbe_q != '1)) cnt_sbe_d = cnt_sbe_q + 1'b1;
      if (dbe_p2_q && (cnt_dbe_q != '1)) cnt_dbe_d = cnt_dbe_q + 1'b1;
      if (!log_valid_q) begin
        log_valid_d = 1'b1;
        log_dbe_d   = dbe_p2_q;
        log_syn_d   = syn_p2_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      data_p1_q   <= '0;
      syn_p1_q    <= '0;
      byp_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      data_p2_q   <= '0;
      sbe_p2_q    <= 1'b0;
      dbe_p2_q    <= 1'b0;
      syn_p2_q    <= '0;
      cnt_sbe_q   <= '0;
      cnt_dbe_q   <= '0;
      log_valid_q <= 1'b0;
      log_dbe_q   <= 1'b0;
      log_syn_q   <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      data_p1_q   <= data_p1_d;
      syn_p1_q    <= syn_p1_d;
      byp_p1_q    <= byp_p1_d;
      vld_p2_q    <= vld_p2_d;
      data_p2_q   <= data_p2_d;
      sbe_p2_q    <= sbe_p2_d;
      dbe_p2_q    <= dbe_p2_d;
      syn_p2_q    <= syn_p2_d;
      cnt_sbe_q   <= cnt_sbe_d;
      cnt_dbe_q   <= cnt_dbe_d;
      log_valid_q <= log_valid_d;
      log_dbe_q   <= log_dbe_d;
      log_syn_q   <= log_syn_d;
    end
  end

  assign bus.in_ready     = s1_adv;
  assign bus.out_valid    = vld_p2_q;
  assign bus.out_data     = data_p2_q;
  assign bus.out_sbe      = sbe_p2_q;
  assign bus.out_dbe      = dbe_p2_q;
  assign bus.out_syndrome = syn_p2_q;
  assign cnt_sbe          = cnt_sbe_q;
  assign cnt_dbe          = cnt_dbe_q;
  assign log_valid        = log_valid_q;
  assign log_dbe          = log_dbe_q;
  assign log_syndrome     = log_syn_q;

endmodule
